// File: rtl/lcd_frame_sched.sv
// lcd_frame_sched: frame scheduler for an ILI9341-style 16-bit 8080 LCD bus.
// Each frame sets the column/page address window, issues memory-write (0x2C),
// then hands the bus to a DMA engine until it reports the frame done.
// Optional tearing-effect sync: define LCD_FRAME_SCHED_TE_SYNC_EN to start each
// frame on a synchronized TE rising edge; otherwise te_i is ignored.
//
// state        | meaning
// IDLE_S       | bus owned by CPU, waiting for start_stb_i or auto_en_i
// TE_WAIT_S    | bus owned by CPU, waiting for synchronized TE rising edge
// CMD_S        | sequencer drives the 11-write address/command preamble
// DMA_START_S  | one-cycle DMA kick, bus owned by DMA
// DMA_WAIT_S   | bus owned by DMA until busy has been seen high then low

module lcd_frame_sched #(
    parameter int WR_PHASE_CYC = 2,
    parameter int LCD_W        = 320,
    parameter int LCD_H        = 240
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_stb_i,
    input  logic        auto_en_i,
    input  logic [15:0] cpu_data_i,
    input  logic        cpu_wr_i,
    input  logic        cpu_rd_i,
    input  logic        cpu_rs_i,
    input  logic        te_i,
    output logic        dma_start_o,
    input  logic        dma_busy_i,
    input  logic [15:0] dma_data_i,
    input  logic        dma_wr_i,
    output logic [15:0] lcd_data_o,
    output logic        lcd_wr_o,
    output logic        lcd_rd_o,
    output logic        lcd_rs_o,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o
);

    typedef enum logic [2:0] {
        IDLE_S,
        TE_WAIT_S,
        CMD_S,
        DMA_START_S,
        DMA_WAIT_S
    } state_t;

    // Phase counter runs down from 2*WR_PHASE_CYC-1; wr is low while it is in the upper half.
    localparam logic [4:0]  PH_LOAD  = 5'(2 * WR_PHASE_CYC - 1);
    localparam logic [4:0]  PH_LOW   = 5'(WR_PHASE_CYC);
    localparam logic [3:0]  LAST_IDX = 4'd10;
    localparam logic [15:0] COL_END  = 16'(LCD_W - 1);
    localparam logic [15:0] ROW_END  = 16'(LCD_H - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wr_idx;
    logic [4:0] ph_cnt;
    logic       seen;
    logic       te_rise;
    logic       frame_done;
    logic [7:0] seq_byte;
    logic       seq_rs;

`ifdef LCD_FRAME_SCHED_TE_SYNC_EN
    localparam state_t FRAME_ENTRY = TE_WAIT_S;

    logic te_s1;
    logic te_s2;
    logic te_d;

    // Two-flop synchronizer on the asynchronous TE pin plus a delay flop for edge detect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            te_s1 <= 1'b0;
            te_s2 <= 1'b0;
            te_d  <= 1'b0;
        end else begin
            te_s1 <= te_i;
            te_s2 <= te_s1;
            te_d  <= te_s2;
        end
    end

    assign te_rise = te_s2 & ~te_d;
`else
    localparam state_t FRAME_ENTRY = CMD_S;

    logic unused_te;
    assign unused_te = te_i;
    assign te_rise   = 1'b0;
`endif

    assign frame_done = (state == DMA_WAIT_S) && seen && !dma_busy_i;

    // Preamble byte and register-select for the current write index.
    always_comb begin
        seq_byte = 8'h00;
        seq_rs   = 1'b1;
        case (wr_idx)
            4'd0:    begin seq_byte = 8'h2A; seq_rs = 1'b0; end
            4'd3:    seq_byte = COL_END[15:8];
            4'd4:    seq_byte = COL_END[7:0];
            4'd5:    begin seq_byte = 8'h2B; seq_rs = 1'b0; end
            4'd8:    seq_byte = ROW_END[15:8];
            4'd9:    seq_byte = ROW_END[7:0];
            4'd10:   begin seq_byte = 8'h2C; seq_rs = 1'b0; end
            default: ;
        endcase
    end

    // Next-state selection; start_stb_i only matters in IDLE_S, so it is never queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE_S:      if (start_stb_i || auto_en_i) state_nxt = FRAME_ENTRY;
            TE_WAIT_S:   if (te_rise) state_nxt = CMD_S;
            CMD_S:       if (ph_cnt == 5'd0 && wr_idx == LAST_IDX) state_nxt = DMA_START_S;
            DMA_START_S: state_nxt = DMA_WAIT_S;
            DMA_WAIT_S:  if (frame_done) state_nxt = auto_en_i ? FRAME_ENTRY : IDLE_S;
            default:     state_nxt = IDLE_S;
        endcase
    end

    // State, write sequencer, frame counter and registered bus mux.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE_S;
            wr_idx      <= 4'd0;
            ph_cnt      <= 5'd0;
            seen        <= 1'b0;
            frame_cnt_o <= 16'h0000;
            dma_start_o <= 1'b0;
            busy_o      <= 1'b0;
            lcd_data_o  <= 16'h0000;
            lcd_wr_o    <= 1'b1;
            lcd_rd_o    <= 1'b1;
            lcd_rs_o    <= 1'b1;
        end else begin
            state       <= state_nxt;
            busy_o      <= (state_nxt != IDLE_S);
            dma_start_o <= (state_nxt == DMA_START_S);

            if (state == CMD_S) begin
                if (ph_cnt == 5'd0) begin
                    ph_cnt <= PH_LOAD;
                    wr_idx <= (wr_idx == LAST_IDX) ? 4'd0 : wr_idx + 4'd1;
                end else begin
                    ph_cnt <= ph_cnt - 5'd1;
                end
            end else if (state_nxt == CMD_S) begin
                ph_cnt <= PH_LOAD;
                wr_idx <= 4'd0;
            end

            // Held clear outside DMA_WAIT_S so every frame starts with a fresh flag.
            if (state != DMA_WAIT_S) begin
                seen <= 1'b0;
            end else if (dma_busy_i) begin
                seen <= 1'b1;
            end

            if (frame_done) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end

            case (state)
                CMD_S: begin
                    lcd_data_o <= {8'h00, seq_byte};
                    lcd_wr_o   <= !(ph_cnt >= PH_LOW);
                    lcd_rd_o   <= 1'b1;
                    lcd_rs_o   <= seq_rs;
                end
                DMA_START_S, DMA_WAIT_S: begin
                    lcd_data_o <= dma_data_i;
                    lcd_wr_o   <= dma_wr_i;
                    lcd_rd_o   <= 1'b1;
                    lcd_rs_o   <= 1'b1;
                end
                default: begin
                    lcd_data_o <= cpu_data_i;
                    lcd_wr_o   <= cpu_wr_i;
                    lcd_rd_o   <= cpu_rd_i;
                    lcd_rs_o   <= cpu_rs_i;
                end
            endcase
        end
    end

endmodule
